// File: rtl/p09_spi_pkg.sv
// Shared types and constants for the SPI command decoder (states, command codes, control-word bits).
package p09_spi_pkg;

  typedef enum logic [2:0] {
    StCommand = 3'd0,
    StData    = 3'd1,
    StControl = 3'd2,
    StCheck   = 3'd3,
    StDone    = 3'd4
  } state_e;

  localparam logic [1:0] CMD_NOP     = 2'd0;
  localparam logic [1:0] CMD_DATA    = 2'd1;
  localparam logic [1:0] CMD_CONTROL = 2'd2;
  localparam logic [1:0] CMD_END     = 2'd3;

  localparam int unsigned STOP_BIT  = 0;
  localparam int unsigned PAUSE_BIT = 1;
  localparam int unsigned SPEED_LSB = 2;

  // Row address width, never narrower than one bit.
  function automatic int unsigned row_aw(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/p09_row_ptr.sv
// Row pointer for the line store: modulo-NUM_ROWS counter with synchronous clear and increment.
module p09_row_ptr
  import p09_spi_pkg::*;
#(
  parameter int unsigned NUM_ROWS = 8,
  parameter int unsigned ROW_AW   = row_aw(NUM_ROWS)
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [ROW_AW-1:0] ptr_o
);

  localparam logic [ROW_AW-1:0] LastRow = ROW_AW'(NUM_ROWS - 1);

  logic [ROW_AW-1:0] ptr_q, ptr_d;

  // Explicit compare so non-power-of-two row counts wrap correctly.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = (ptr_q == LastRow) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/p09_spi_cmd_ctrl.sv
// Command decoder between the SPI deserialiser and the line store: bursts, control, end-of-frame.
// Define P09_CMD_CHECKSUM_EN to add the XOR checksum word after every data burst.
module p09_spi_cmd_ctrl
  import p09_spi_pkg::*;
#(
  parameter int unsigned WORD_W   = 16,
  parameter int unsigned LINE_W   = 13,
  parameter int unsigned NUM_ROWS = 8,
  parameter int unsigned SPEED_W  = 4,
  localparam int unsigned ROW_AW  = row_aw(NUM_ROWS)
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic               start_i,
  input  logic               word_en_i,
  input  logic [WORD_W-1:0]  word_i,
  output logic [LINE_W-1:0]  line_o,
  output logic [ROW_AW-1:0]  line_addr_o,
  output logic               write_line_o,
  output logic               shift_line_o,
  output logic               stop_game_o,
  output logic               paused_o,
  output logic [SPEED_W-1:0] speed_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  state_e             state_q, state_d;
  logic [ROW_AW-1:0]  burst_q, burst_d;
  logic               shift_q;
  logic               paused_q, paused_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic               err_q, err_d;
`ifdef P09_CMD_CHECKSUM_EN
  logic [LINE_W-1:0]  checksum_q, checksum_d;
`endif

  logic [1:0]        cmd;
  logic [ROW_AW-1:0] len;
  logic              unused_word;

  assign cmd         = word_i[1:0];
  assign len         = word_i[ROW_AW+1:2];
  assign unused_word = ^word_i;

  assign line_o       = word_i[LINE_W-1:0];
  assign write_line_o = (state_q == StData) && word_en_i && !start_i;
  assign stop_game_o  = (state_q == StControl) && word_en_i && word_i[STOP_BIT] && !start_i;
  assign busy_o       = (state_q == StData) || (state_q == StControl) || (state_q == StCheck);
  assign done_o       = (state_q == StDone);
  assign shift_line_o = shift_q;
  assign paused_o     = paused_q;
  assign speed_o      = speed_q;
  assign err_o        = err_q;

  p09_row_ptr #(
    .NUM_ROWS (NUM_ROWS),
    .ROW_AW   (ROW_AW)
  ) u_row_ptr (
    .clk   (clk),
    .nRst  (nRst),
    .clr_i (start_i),
    .inc_i (write_line_o),
    .ptr_o (line_addr_o)
  );

  always_comb begin
    state_d  = state_q;
    burst_d  = burst_q;
    paused_d = paused_q;
    speed_d  = speed_q;
    err_d    = err_q;
`ifdef P09_CMD_CHECKSUM_EN
    checksum_d = checksum_q;
`endif
    // start wins over a same-cycle word, which is dropped.
    if (start_i) begin
      state_d = StCommand;
      err_d   = 1'b0;
    end else if (word_en_i) begin
      case (state_q)
        StCommand: begin
          case (cmd)
            CMD_NOP: begin
              if (len != '0) err_d = 1'b1;
            end
            CMD_DATA: begin
              state_d = StData;
              burst_d = len;
`ifdef P09_CMD_CHECKSUM_EN
              checksum_d = '0;
`endif
            end
            CMD_CONTROL: state_d = StControl;
            default:     state_d = StDone;
          endcase
        end
        StData: begin
          burst_d = burst_q - 1'b1;
`ifdef P09_CMD_CHECKSUM_EN
          checksum_d = checksum_q ^ word_i[LINE_W-1:0];
          if (burst_q == '0) state_d = StCheck;
`else
          if (burst_q == '0) state_d = StCommand;
`endif
        end
        StControl: begin
          paused_d = word_i[PAUSE_BIT];
          speed_d  = word_i[SPEED_LSB +: SPEED_W];
          state_d  = StCommand;
        end
`ifdef P09_CMD_CHECKSUM_EN
        StCheck: begin
          if (word_i[LINE_W-1:0] != checksum_q) err_d = 1'b1;
          state_d = StCommand;
        end
`endif
        StDone: state_d = StDone;
        default: state_d = StCommand;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q  <= StCommand;
      burst_q  <= '0;
      shift_q  <= 1'b0;
      paused_q <= 1'b0;
      speed_q  <= '0;
      err_q    <= 1'b0;
`ifdef P09_CMD_CHECKSUM_EN
      checksum_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      shift_q  <= write_line_o;
      paused_q <= paused_d;
      speed_q  <= speed_d;
      err_q    <= err_d;
`ifdef P09_CMD_CHECKSUM_EN
      checksum_q <= checksum_d;
`endif
    end
  end

endmodule
